// File: rtl/stage_reg_pipe.sv
// Generic pipeline stage register: valid/ready handshake, optional two-entry
// skid buffer, flush-to-bubble and a saturating back-pressure counter.
module stage_reg_pipe #(
  parameter int unsigned             WIDTH  = 199,
  parameter logic [WIDTH-1:0]        BUBBLE = '0,
  parameter int unsigned             SKID   = 1,
  parameter int unsigned             CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             accept;
  logic             main_free;

  // With the skid buffer, in_ready comes straight from a flop so out_ready
  // never reaches the upstream stage combinationally.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = ~skid_valid_q;
    end else begin : g_direct_ready
      assign in_ready = ~out_valid_q | out_ready;
    end
  endgenerate

  assign accept    = in_valid & in_ready;
  assign main_free = ~out_valid_q | out_ready;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    skid_valid_d  = skid_valid_q;
    skid_data_d   = skid_data_q;
    stall_count_d = stall_count_q;

    if (out_valid_q && !out_ready && stall_count_q != CNT_MAX) begin
      stall_count_d = stall_count_q + 1'b1;
    end

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      out_data_d   = BUBBLE;
    end else if (SKID != 0) begin
      if (main_free) begin
        if (skid_valid_q) begin
          out_valid_d  = 1'b1;
          out_data_d   = skid_data_q;
          skid_valid_d = accept;
          if (accept) begin
            skid_data_d = in_data;
          end
        end else if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end else begin
      if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State changes on the falling edge to line up with the other stage registers.
  always_ff @(negedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= BUBBLE;
      skid_valid_q  <= 1'b0;
      skid_data_q   <= BUBBLE;
      stall_count_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      skid_valid_q  <= skid_valid_d;
      skid_data_q   <= skid_data_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign stall_count = stall_count_q;

endmodule

// File: doc/stage_reg_pipe.md
# stage_reg_pipe

Parametrised pipeline stage register with valid/ready handshake, optional two-entry skid buffer, flush-to-bubble and a saturating stall counter. It replaces the fixed per-stage latches between IF/ID/EX/MEM/WB with one generic block. A stage's fields are packed into one payload bus. Downstream back-pressure stalls the stage without losing data, and a flush (branch/exception) inserts a bubble.

## Interface
Parameters:
- WIDTH, 199: payload bits (packed stage fields: NextPC, Instruction, ALUOut, ALUOutHi, MemOut, WriteReg, control bits).
- BUBBLE, 0: payload value presented after reset or flush (all-zero = `sll $0,$0,0` NOP, WriteReg 0).
- SKID, 1: 1 = two-entry skid buffer, registered `in_ready`; 0 = single register, combinational `in_ready`.
- CNT_W, 16: stall counter width.

Ports:
- clk, in, 1: clock; all state updates on the falling edge, matching the other stage registers.
- rst, in, 1: synchronous, active-high reset, sampled on the falling edge of clk.
- in_valid, in, 1: upstream payload valid.
- in_ready, out, 1: block can accept `in_data` this cycle.
- in_data, in, WIDTH: upstream payload.
- flush, in, 1: discard all held and incoming payloads.
- out_valid, out, 1: `out_data` valid to downstream.
- out_ready, in, 1: downstream accepts `out_data`.
- out_data, out, WIDTH: payload to next stage.
- stall_count, out, CNT_W: edges with out_valid=1 and out_ready=0, saturating.

## Operation
- Accept: edge where in_valid & in_ready. Deliver: edge where out_valid & out_ready.
- Priority at each edge: rst > flush > normal transfer.
- rst: out_valid=0, skid empty, out_data=BUBBLE, stall_count=0.
- flush (rst=0): out_valid=0, skid emptied, out_data=BUBBLE. A payload offered at the same edge is dropped even if in_ready=1. stall_count is unaffected.
- SKID=1: state is main register (out_valid/out_data) plus skid register (skid_valid/skid_data).
  - in_ready = ~skid_valid, driven directly from the register.
  - Main loads when (~out_valid | out_ready):
    - skid_valid=1: main ← skid, skid empties, and an accepted input enters skid.
    - else: main ← input if accepted; otherwise out_valid ← 0.
  - Main holds (out_valid & ~out_ready): an accepted input goes to skid (skid_valid ← 1).
  - Never more than 2 payloads held. Order is strictly FIFO.
- SKID=0: in_ready = ~out_valid | out_ready (combinational). Main loads the input on accept; out_valid clears on deliver without accept.
- out_data when out_valid=0 holds its last value, except BUBBLE after rst/flush.
- stall_count: +1 on each non-rst edge with out_valid & ~out_ready (a flush edge included, evaluated before clear). It holds at 2^CNT_W−1 and never wraps.

## Timing
- Latency: payload accepted at edge n is visible on out_data after edge n (1 edge) when main is free.
- Throughput: 1 payload per cycle with out_ready held high, both modes.
- SKID=1: after out_ready drops, one more payload is accepted, then in_ready=0 from the following edge. in_ready returns to 1 one edge after the first deliver.
- Reset values: out_valid=0, out_data=BUBBLE, in_ready=1, stall_count=0.
- rst or flush asserted mid-stall: both entries discarded in the same edge; in_ready=1 after that edge.
- in_data/in_valid may change freely while in_ready=0. No combinational path from out_ready to in_ready when SKID=1.

## Test plan
- Reset then stream 0x1..0x8 with out_ready=1 (SKID=1) → out_data 0x1..0x8 on consecutive cycles, 1-edge latency, in_ready stays 1, stall_count=0.
- SKID=1: send 0xA, 0xB, 0xC while out_ready=0 → 0xA in main, 0xB in skid, in_ready=0, 0xC not accepted. Raise out_ready for 3 cycles → 0xA, 0xB, 0xC in order with no loss or duplication. stall_count equals the number of stalled edges.
- Flush with both entries full and in_valid=1 carrying 0xD → out_valid=0, out_data=BUBBLE, in_ready=1. 0xD is never delivered.
- rst asserted mid-stall (stall_count=5) → all outputs return to reset values next edge, stall_count=0.
- CNT_W=3, out_valid=1, out_ready=0 for 10 cycles → stall_count reaches 7 and holds.
- SKID=0: same stream as the first test, then a stall → in_ready tracks ~out_valid | out_ready combinationally and order is preserved.
